// File: rtl/cu_pkg.sv
// Shared types and constants for the control-unit interrupt capture slice.
package cu_pkg;
  typedef enum logic [1:0] {
    S_HIGH = 2'd0,
    S_FILT = 2'd1,
    S_LOW  = 2'd2
  } nmi_st_t;

  localparam int   CNT_W    = 4;
  localparam logic FLG_ACT  = 1'b0;
  localparam logic FLG_IDLE = 1'b1;
endpackage

// File: rtl/cu_sync.sv
// Multi-flop synchroniser for an asynchronous active-low pin; resets to the idle (high) level.
module cu_sync #(
  parameter int STG = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [STG-1:0] sync_q;
  logic [STG-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STG-2:0], d};
  end

  always_ff @(posedge clk) begin
    if (rst) sync_q <= '1;
    else     sync_q <= sync_d;
  end

  assign q = sync_q[STG-1];
endmodule

// File: rtl/cu_int_capture.sv
// Interrupt capture: synchronises /NMI and /IRQ, filters and edge-latches NMI, blanks IRQ after service.
module cu_int_capture
  import cu_pkg::*;
#(
  parameter int SYNC_STG  = 2,
  parameter int NMI_FILT  = 2,
  parameter int IRQ_BLANK = 3
) (
  input  logic clk,
  input  logic b_rst,
  input  logic b_nmi,
  input  logic b_irq,
  input  logic bnmi_sd,
  input  logic birq_sd,
  output logic bnmi_flg,
  output logic birq_flg,
  output logic nmi_ovr
);
  localparam logic [CNT_W-1:0] FILT_C  = CNT_W'(NMI_FILT);
  localparam logic [CNT_W-1:0] BLANK_C = CNT_W'(IRQ_BLANK);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  logic nmi_s, irq_s;
  nmi_st_t st_q, st_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, blank_q, blank_d;
  logic [SYNC_STG-1:0] fill_q, fill_d;
  logic arm_q, arm_d;
  logic bnmi_flg_q, bnmi_flg_d, nmi_ovr_q, nmi_ovr_d, birq_flg_q, birq_flg_d;
  logic fire;

  cu_sync #(.STG(SYNC_STG)) u_sync_nmi (.clk(clk), .rst(b_rst), .d(b_nmi), .q(nmi_s));
  cu_sync #(.STG(SYNC_STG)) u_sync_irq (.clk(clk), .rst(b_rst), .d(b_irq), .q(irq_s));

  // The synchroniser restarts at 1 after reset, so a pin already low would look like a fresh
  // falling edge. Edges are only accepted once a genuine high has come out of the chain.
  always_comb begin
    fill_d = {fill_q[SYNC_STG-2:0], 1'b1};
    arm_d  = arm_q | (fill_q[SYNC_STG-1] & nmi_s);
  end

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    fire  = 1'b0;
    case (st_q)
      S_HIGH: begin
        if (!nmi_s && arm_q) begin
          if (NMI_FILT == 1) begin
            st_d = S_LOW;
            fire = 1'b1;
          end else begin
            st_d  = S_FILT;
            cnt_d = ONE_C;
          end
        end
      end
      S_FILT: begin
        if (nmi_s) begin
          st_d  = S_HIGH;
          cnt_d = '0;
        end else if (cnt_q + ONE_C == FILT_C) begin
          st_d  = S_LOW;
          cnt_d = '0;
          fire  = 1'b1;
        end else begin
          cnt_d = cnt_q + ONE_C;
        end
      end
      S_LOW: begin
        if (nmi_s) st_d = S_HIGH;
      end
      default: begin
        st_d  = S_HIGH;
        cnt_d = '0;
      end
    endcase
  end

  // A fire coinciding with a service strobe replaces the serviced NMI rather than overrunning it.
  always_comb begin
    bnmi_flg_d = bnmi_flg_q;
    nmi_ovr_d  = nmi_ovr_q;
    if (fire) begin
      bnmi_flg_d = FLG_ACT;
      if (bnmi_flg_q == FLG_ACT && bnmi_sd) nmi_ovr_d = 1'b1;
    end else if (!bnmi_sd) begin
      bnmi_flg_d = FLG_IDLE;
    end
  end

  always_comb begin
    if (!birq_sd)              blank_d = BLANK_C;
    else if (blank_q != '0)    blank_d = blank_q - ONE_C;
    else                       blank_d = blank_q;
    birq_flg_d = (blank_d != '0) ? FLG_IDLE : irq_s;
  end

  always_ff @(posedge clk) begin
    if (b_rst) begin
      st_q       <= S_HIGH;
      cnt_q      <= '0;
      blank_q    <= '0;
      fill_q     <= '0;
      arm_q      <= 1'b0;
      bnmi_flg_q <= FLG_IDLE;
      birq_flg_q <= FLG_IDLE;
      nmi_ovr_q  <= 1'b0;
    end else begin
      st_q       <= st_d;
      cnt_q      <= cnt_d;
      blank_q    <= blank_d;
      fill_q     <= fill_d;
      arm_q      <= arm_d;
      bnmi_flg_q <= bnmi_flg_d;
      birq_flg_q <= birq_flg_d;
      nmi_ovr_q  <= nmi_ovr_d;
    end
  end

  assign bnmi_flg = bnmi_flg_q;
  assign birq_flg = birq_flg_q;
  assign nmi_ovr  = nmi_ovr_q;
endmodule

// File: tb/tb_cu_int_capture.sv
// Scoreboarded bench for cu_int_capture: directed scenarios followed by random pin/strobe traffic.
module tb_cu_int_capture;
  localparam int SYNC_STG  = 2;
  localparam int NMI_FILT  = 2;
  localparam int IRQ_BLANK = 3;

  logic clk = 1'b0;
  logic b_rst = 1'b1, b_nmi = 1'b0, b_irq = 1'b0, bnmi_sd = 1'b1, birq_sd = 1'b1;
  logic bnmi_flg, birq_flg, nmi_ovr;

  typedef struct packed {logic nf; logic irf; logic ov;} exp_t;
  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  cu_int_capture #(.SYNC_STG(SYNC_STG), .NMI_FILT(NMI_FILT), .IRQ_BLANK(IRQ_BLANK)) dut (
    .clk(clk), .b_rst(b_rst), .b_nmi(b_nmi), .b_irq(b_irq),
    .bnmi_sd(bnmi_sd), .birq_sd(birq_sd),
    .bnmi_flg(bnmi_flg), .birq_flg(birq_flg), .nmi_ovr(nmi_ovr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%b want=%b", name, $time, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0d want=%0d", name, $time, act, exp);
    end
  endtask

  // Reference model: pins delayed SYNC_STG samples, NMI fires when a low run (after a real high)
  // reaches NMI_FILT samples; IRQ blanked for IRQ_BLANK cycles after each service strobe.
  bit   nq[$];
  bit   iq[$];
  int   vcnt, run, blank;
  bit   armed, m_flg, m_ovr, m_irq;

  always @(posedge clk) begin : model
    bit ns, is, fire;
    exp_t e;
    if (b_rst) begin
      nq.delete();
      iq.delete();
      for (int i = 0; i < SYNC_STG; i++) begin
        nq.push_back(1'b1);
        iq.push_back(1'b1);
      end
      vcnt = 0; armed = 0; run = 0; blank = 0;
      m_flg = 1; m_ovr = 0; m_irq = 1;
    end else begin
      ns = nq.pop_front();
      is = iq.pop_front();
      nq.push_back(b_nmi);
      iq.push_back(b_irq);
      fire = 0;
      if (ns) begin
        run = 0;
        if (vcnt >= SYNC_STG) armed = 1;
      end else if (armed) begin
        run++;
        if (run == NMI_FILT) fire = 1;
      end
      vcnt++;
      if (fire) begin
        if (!m_flg && bnmi_sd) m_ovr = 1;
        m_flg = 0;
      end else if (!bnmi_sd) begin
        m_flg = 1;
      end
      if (!birq_sd)       blank = IRQ_BLANK;
      else if (blank > 0) blank--;
      m_irq = (blank != 0) ? 1'b1 : is;
    end
    e.nf  = m_flg;
    e.irf = m_irq;
    e.ov  = m_ovr;
    sb.push_back(e);
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("bnmi_flg", bnmi_flg, e.nf);
      chk("birq_flg", birq_flg, e.irf);
      chk("nmi_ovr", nmi_ovr, e.ov);
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic nmi_service();
    bnmi_sd = 1'b0; cyc(1); bnmi_sd = 1'b1;
  endtask

  task automatic irq_service();
    birq_sd = 1'b0; cyc(1); birq_sd = 1'b1;
  endtask

  initial begin : stim
    int lat;
    bit found;
    int nhold, ihold;
    // T1: reset with both pins low
    b_rst = 1'b1; b_nmi = 1'b0; b_irq = 1'b0;
    cyc(3);
    b_rst = 1'b0;
    cyc(6);
    b_nmi = 1'b1; b_irq = 1'b1;
    cyc(6);

    // T2: qualified NMI edge, exact latency, single fire, then service
    b_nmi = 1'b0;
    lat = 0; found = 0;
    for (int k = 1; k <= 20; k++) begin
      cyc(1);
      if (!found && bnmi_flg == 1'b0) begin
        found = 1; lat = k;
      end
    end
    chk_int("nmi_latency", lat, SYNC_STG + NMI_FILT);
    nmi_service();
    cyc(5);
    b_nmi = 1'b1;
    cyc(5);

    // T3: glitch rejection, then minimal qualifying pulse
    b_nmi = 1'b0; cyc(1); b_nmi = 1'b1; cyc(6);
    b_nmi = 1'b0; cyc(2); b_nmi = 1'b1; cyc(6);
    nmi_service(); cyc(2);

    // T4a: second edge before service -> overrun
    b_nmi = 1'b0; cyc(6); b_nmi = 1'b1; cyc(4);
    b_nmi = 1'b0; cyc(6); b_nmi = 1'b1; cyc(4);
    // T4b: after reset, second edge coincident with service
    b_rst = 1'b1; cyc(1); b_rst = 1'b0; cyc(6);
    b_nmi = 1'b0; cyc(6); b_nmi = 1'b1; cyc(4);
    b_nmi = 1'b0; cyc(3);
    nmi_service();
    cyc(4);
    b_nmi = 1'b1; cyc(4);

    // T5: IRQ blanking, single and re-triggered
    b_irq = 1'b0; cyc(5);
    irq_service(); cyc(6);
    irq_service(); cyc(1); irq_service(); cyc(8);
    birq_sd = 1'b0; cyc(4); birq_sd = 1'b1; cyc(5);
    b_irq = 1'b1; cyc(3);

    // T6: reset with pending NMI and pin still low
    b_nmi = 1'b0; cyc(8);
    b_rst = 1'b1; cyc(1); b_rst = 1'b0;
    cyc(10);
    b_nmi = 1'b1; cyc(4);
    b_nmi = 1'b0; cyc(8);
    nmi_service(); b_nmi = 1'b1; cyc(4);

    // Random traffic
    nhold = 1; ihold = 1;
    for (int i = 0; i < 3000; i++) begin
      nhold--;
      if (nhold <= 0) begin
        b_nmi = ~b_nmi;
        nhold = $urandom_range(1, 5);
      end
      ihold--;
      if (ihold <= 0) begin
        b_irq = ~b_irq;
        ihold = $urandom_range(1, 8);
      end
      bnmi_sd = ($urandom_range(0, 7) != 0);
      birq_sd = ($urandom_range(0, 5) != 0);
      b_rst   = ($urandom_range(0, 299) == 0);
      cyc(1);
    end
    b_rst = 1'b0; bnmi_sd = 1'b1; birq_sd = 1'b1;
    cyc(4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
